// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect and stall handling
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_plus_4_f,
   output logic        fetch_valid
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, buf_q, buf_d, tgt;
   // next state, pc and buffer; redirect targets are forced word-aligned
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      tgt     = redirect_pc & ~32'h3;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            pc_d    = redirect ? tgt : pc_q;
         end
         REQ: begin
            state_d = redirect ? DROP : WAIT;
            pc_d    = redirect ? tgt : pc_q;
         end
         WAIT: begin
            if (redirect) begin
               pc_d    = tgt;
               state_d = imem_rvalid ? REQ : DROP;
            end else if (imem_rvalid) begin
               buf_d   = imem_rdata;
               state_d = HOLD;
            end
         end
         DROP: begin
            pc_d    = redirect ? tgt : pc_q;
            state_d = imem_rvalid ? REQ : DROP;
         end
         HOLD: begin
            pc_d    = redirect ? tgt : (stall_f ? pc_q : pc_q + 32'd4);
            state_d = (redirect || !stall_f) ? REQ : HOLD;
         end
         default: state_d = IDLE;
      endcase
   end
   // state, pc and instruction buffer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end
   // outputs decoded purely from registered state
   always_comb begin
      imem_req    = state_q == REQ;
      fetch_valid = state_q == HOLD;
      imem_addr   = pc_q;
      pc_plus_4_f = pc_q + 32'd4;
      instr_f     = fetch_valid ? buf_q : 32'h0;
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit plus async reset sequence
module tb_fetch_unit;
   logic        clk = 1'b0, rst = 1'b0, stall_f = 1'b0, redirect = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rdata = '0;
   logic        imem_req, fetch_valid;
   logic [31:0] imem_addr, instr_f, pc_plus_4_f;
   int          n_vec = 0, n_err = 0;

   typedef struct {
      logic        stall, red;
      logic [31:0] rpc;
      logic        rv;
      logic [31:0] rd;
      logic        req;
      logic [31:0] addr;
      logic        fv;
      logic [31:0] instr, pp4;
   } vec_t;
   vec_t tbl[34];

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_f(instr_f), .pc_plus_4_f(pc_plus_4_f), .fetch_valid(fetch_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic req, input logic [31:0] addr, input logic fv,
                      input logic [31:0] instr, input logic [31:0] pp4);
      n_vec++;
      if (imem_req !== req || imem_addr !== addr || fetch_valid !== fv || instr_f !== instr || pc_plus_4_f !== pp4) begin
         n_err++;
         $display("FAIL %s: got req=%b addr=%h fv=%b instr=%h pp4=%h, want req=%b addr=%h fv=%b instr=%h pp4=%h",
                  nm, imem_req, imem_addr, fetch_valid, instr_f, pc_plus_4_f, req, addr, fv, instr, pp4);
      end
   endtask

   initial begin
      //        stall red rpc            rv rd              req addr           fv instr          pp4
      tbl[0]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4};
      tbl[1]  = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4};
      tbl[2]  = '{0, 0, 32'h0,         1, 32'h24080005, 0, 32'h0,        0, 32'h0,        32'h4};
      tbl[3]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h24080005, 32'h4};
      tbl[4]  = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h8};
      tbl[5]  = '{0, 0, 32'h0,         1, 32'h11111111, 0, 32'h4,        0, 32'h0,        32'h8};
      tbl[6]  = '{1, 0, 32'h0,         0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8};
      tbl[7]  = '{1, 0, 32'h0,         0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8};
      tbl[8]  = '{1, 0, 32'h0,         0, 32'h0,        0, 32'h4,        1, 32'h11111111, 32'h8};
      tbl[9]  = '{0, 0, 32'h0,         1, 32'hFFFF0000, 0, 32'h4,        1, 32'h11111111, 32'h8};
      tbl[10] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h8,        0, 32'h0,        32'hC};
      tbl[11] = '{0, 1, 32'h40,        0, 32'h0,        0, 32'h8,        0, 32'h0,        32'hC};
      tbl[12] = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h40,       0, 32'h0,        32'h44};
      tbl[13] = '{0, 0, 32'h0,         1, 32'hDEADBEEF, 0, 32'h40,       0, 32'h0,        32'h44};
      tbl[14] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h44};
      tbl[15] = '{0, 1, 32'h80,        1, 32'hCAFEF00D, 0, 32'h40,       0, 32'h0,        32'h44};
      tbl[16] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h80,       0, 32'h0,        32'h84};
      tbl[17] = '{0, 0, 32'h0,         1, 32'h00A00093, 0, 32'h80,       0, 32'h0,        32'h84};
      tbl[18] = '{1, 1, 32'h43,        0, 32'h0,        0, 32'h80,       1, 32'h00A00093, 32'h84};
      tbl[19] = '{0, 1, 32'h100,       0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h44};
      tbl[20] = '{0, 1, 32'h204,       0, 32'h0,        0, 32'h100,      0, 32'h0,        32'h104};
      tbl[21] = '{0, 0, 32'h0,         1, 32'h77777777, 0, 32'h204,      0, 32'h0,        32'h208};
      tbl[22] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h204,      0, 32'h0,        32'h208};
      tbl[23] = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h204,      0, 32'h0,        32'h208};
      tbl[24] = '{0, 0, 32'h0,         1, 32'h12345678, 0, 32'h204,      0, 32'h0,        32'h208};
      tbl[25] = '{0, 1, 32'hFFFFFFFF,  0, 32'h0,        0, 32'h204,      1, 32'h12345678, 32'h208};
      tbl[26] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        32'h0};
      tbl[27] = '{0, 0, 32'h0,         1, 32'h55AA55AA, 0, 32'hFFFFFFFC, 0, 32'h0,        32'h0};
      tbl[28] = '{0, 0, 32'h0,         0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h55AA55AA, 32'h0};
      tbl[29] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4};
      tbl[30] = '{0, 0, 32'h0,         1, 32'h0BADF00D, 0, 32'h0,        0, 32'h0,        32'h4};
      tbl[31] = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0BADF00D, 32'h4};
      tbl[32] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h8};
      tbl[33] = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h4,        0, 32'h0,        32'h8};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", 0, 32'h0, 0, 32'h0, 32'h4);
      rst = 1'b1;
      for (int i = 0; i < 34; i++) begin
         chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].fv, tbl[i].instr, tbl[i].pp4);
         stall_f     = tbl[i].stall;
         redirect    = tbl[i].red;
         redirect_pc = tbl[i].rpc;
         imem_rvalid = tbl[i].rv;
         imem_rdata  = tbl[i].rd;
         @(negedge clk);
      end

      chk("wait_before_rst", 0, 32'h4, 0, 32'h0, 32'h8);
      #2 rst = 1'b0;
      #1 chk("async_rst", 0, 32'h0, 0, 32'h0, 32'h4);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0BAD0;
      @(negedge clk);
      chk("rst_held", 0, 32'h0, 0, 32'h0, 32'h4);
      rst = 1'b1;
      @(negedge clk);
      chk("req_after_rel", 1, 32'h0, 0, 32'h0, 32'h4);
      imem_rvalid = 1'b0;
      @(negedge clk);
      chk("wait_after_rel", 0, 32'h0, 0, 32'h0, 32'h4);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h24080005;
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("hold_after_rel", 0, 32'h0, 1, 32'h24080005, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall_f  input  1  decode stage stalled; the presented instruction is not consumed this cycle.
REQ-005 redirect  input  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-006 redirect_pc  input  32  target address; bits [1:0] ignored and treated as 00.
REQ-007 imem_req  output  1  one-cycle instruction-memory read request.
REQ-008 imem_addr  output  32  read address, equal to the internal pc.
REQ-009 imem_rvalid  input  1  read data valid, at least 1 cycle after imem_req; one outstanding request maximum.
REQ-010 imem_rdata  input  32  read data, sampled only when imem_rvalid=1.
REQ-011 instr_f  output  32  instruction toward the decode pipeline register; 32'h0 (NOP) when fetch_valid=0.
REQ-012 pc_plus_4_f  output  32  pc+4, modulo 2^32, at all times.
REQ-013 fetch_valid  output  1  instr_f holds a real fetched instruction.

Function
REQ-014 States: IDLE, REQ, WAIT, DROP, HOLD; all outputs decoded from registered state, pc and instruction buffer only.
REQ-015 imem_req=1 exactly when state=REQ; fetch_valid=1 exactly when state=HOLD.
REQ-016 IDLE: entered only from reset; next state REQ (redirect here loads pc<=redirect_pc).
REQ-017 REQ: next state WAIT; if redirect, pc<=redirect_pc and next state DROP instead.
REQ-018 WAIT, redirect=1: pc<=redirect_pc; next state REQ if imem_rvalid=1 (data discarded), else DROP.
REQ-019 WAIT, redirect=0: imem_rvalid=1 -> buffer<=imem_rdata, next state HOLD; else stay.
REQ-020 DROP: imem_rvalid=1 -> response discarded, next state REQ; redirect in DROP updates pc with the same transition.
REQ-021 HOLD: redirect=1 (priority over stall_f) -> pc<=redirect_pc, next state REQ.
REQ-022 HOLD: redirect=0, stall_f=0 -> pc<=pc+4, next state REQ; stall_f=1 -> stay, outputs stable.
REQ-023 imem_rvalid outside WAIT/DROP is ignored without state change.
REQ-024 pc arithmetic is 32-bit and wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-025 Latency: imem_rvalid in cycle N gives fetch_valid=1 in cycle N+1; consumption in cycle M gives imem_req in cycle M+1.

Reset
REQ-026 While rst=0, regardless of clk: state=IDLE, pc=RESET_PC, buffer=0, imem_req=0, fetch_valid=0, instr_f=0, imem_addr=RESET_PC, pc_plus_4_f=RESET_PC+4.
REQ-027 Reset asserted mid-operation abandons any outstanding request; first request follows rst release by exactly one cycle (IDLE -> REQ).

Verification
REQ-028 Release rst; memory returns 32'h2408_0005 one cycle after req -> imem_req cycle 1 addr 0x0, fetch_valid=1 instr_f=0x24080005 pc_plus_4_f=0x4 cycle 3; stall_f=0 -> imem_req addr 0x4 cycle 4.
REQ-029 In HOLD hold stall_f=1 for 3 cycles -> instr_f, pc_plus_4_f, fetch_valid unchanged, imem_req=0 throughout.
REQ-030 Redirect to 0x40 in WAIT, rvalid 0xDEADBEEF two cycles later -> data never reaches instr_f, fetch_valid stays 0, next imem_req addr 0x40.
REQ-031 Redirect to 0x80 and imem_rvalid in same WAIT cycle -> data discarded, imem_req addr 0x80 next cycle.
REQ-032 In HOLD, redirect=1 with redirect_pc=0x43 and stall_f=1 -> fetch_valid=0 next cycle, imem_req addr 0x40.
REQ-033 pc=0xFFFF_FFFC in HOLD -> pc_plus_4_f=0x0; consume -> imem_req addr 0x0; rst pulsed during WAIT -> outputs at reset values immediately, stray rvalid after release ignored.
